spike_dispatcher: RTL and testbench
===================================

Name: spike_dispatcher

Overview:
- Transmit side of the spike/source-address interface consumed by the MAC units.
- Captures the fire bitmap of a local group of neuron units at the end of each timestep.
- Serialises each fired neuron's 12-bit address onto a valid/ready address bus, one address per accepted transfer.
- After the last address, issues a one-cycle clear pulse that marks the timestep boundary for downstream accumulation.

Parameters:
- NUMBER_OF_UNITS, 10, number of neuron units whose spikes this block dispatches.
- NUMBER_OF_ADDRESS_BITS, 12, width of neuron/source addresses.
- BASE_ADDRESS, 12'h000, address of unit 0; unit k is transmitted as BASE_ADDRESS + k (modulo 2^NUMBER_OF_ADDRESS_BITS).

Ports:
- CLK  input  1  clock; all logic is on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- timestep_done  input  1  single-cycle pulse: the spikes bitmap is valid this cycle.
- spikes  input  NUMBER_OF_UNITS  fire bitmap; bit k set means unit k fired.
- source_address  output  NUMBER_OF_ADDRESS_BITS  address of the spiking neuron.
- address_valid  output  1  source_address holds a valid address.
- address_ready  input  1  receiver accepts the address this cycle.
- clear  output  1  single-cycle end-of-dispatch pulse.
- busy  output  1  high in SEND or CLEAR.
- overrun  output  1  sticky; set when timestep_done arrives while busy.

Behaviour:
- Reset: on RESET=1 at a clock edge, the block forces the following values; it overrides any in-progress transfer, abandons the pending bitmap, and produces no clear.
  - state=IDLE, pending=0.
  - source_address=0, address_valid=0, clear=0, busy=0, overrun=0.
- State IDLE:
  - On timestep_done: latch spikes into pending.
  - If spikes is nonzero, go to SEND; otherwise go to CLEAR.
- State SEND:
  - idx = index of the lowest set bit of pending.
  - source_address = BASE_ADDRESS + idx, registered; address_valid=1.
  - Transfer occurs when address_valid && address_ready at a clock edge; then bit idx of pending is cleared.
  - Next cycle presents the next lowest set bit, so back-to-back transfers run at one per cycle when address_ready is held high.
  - If the transferred bit was the last set bit, go to CLEAR; address_valid drops the same edge.
- Handshake rules:
  - While address_valid=1 and address_ready=0, source_address is held stable.
  - address_valid never drops without a transfer.
- State CLEAR: clear=1 for exactly one cycle, then return to IDLE.
- Latency:
  - timestep_done at edge t puts the first address_valid at cycle t+1.
  - With address_ready held high and n spikes, clear is asserted in cycle t+n+1.
  - Empty bitmap: clear is asserted in cycle t+1.
- Output decoding: busy = (state != IDLE).
- Timestep collision: timestep_done while busy is ignored (the new bitmap is dropped) and overrun is set; overrun is cleared only by RESET.
- All-ones bitmap: NUMBER_OF_UNITS transfers in ascending address order.
- Wrap-around: BASE_ADDRESS + idx wraps modulo 2^NUMBER_OF_ADDRESS_BITS.

Optional Feature:
- Macro SPIKE_DISPATCH_COUNT_EN.
- Defined:
  - Adds output spike_count [$clog2(NUMBER_OF_UNITS+1)-1:0].
  - Reset to 0; loaded with 0 on the IDLE timestep_done; increments on every transfer.
  - Holds its final value from the clear cycle until the next accepted timestep_done.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package spike_dispatch_pkg holds:
  - state enum IDLE/SEND/CLEAR (2-bit encoding 0/1/2);
  - default address width constant 12;
  - default unit count constant 10.
- One sub-module: lowest_set_index, a combinational priority encoder.
  - Inputs: pending bitmap.
  - Outputs: index and any-set flag.
  - Parameterised by NUMBER_OF_UNITS.

Test Plan:
- Reset mid-SEND (spikes=10'b1111111111, RESET after 3 transfers):
  - Next cycle: address_valid=0, busy=0, no clear.
  - A following timestep_done with spikes=10'b0000000001 yields a single address 0x000 then clear.
- Basic burst (BASE_ADDRESS=0x100, spikes=10'b0000100101, address_ready=1):
  - Addresses 0x100, 0x102, 0x105 on consecutive cycles.
  - clear in cycle t+4; busy low from t+5.
- Backpressure (same bitmap, address_ready low for 3 cycles while 0x102 is valid):
  - source_address held at 0x102 throughout.
  - No duplicate or skipped addresses; clear follows 0x105.
- Empty timestep (spikes=0): no address_valid; clear pulse in cycle t+1 only.
- Overrun (second timestep_done pulse while SEND is active):
  - overrun=1 and stays set.
  - The first burst completes unchanged; the second bitmap is never sent.
- Wrap and count (BASE_ADDRESS=0xFFE, spikes=10'b0000000111, SPIKE_DISPATCH_COUNT_EN defined):
  - Addresses 0xFFE, 0xFFF, 0x000.
  - spike_count=3 at clear.

Source files
------------

// File: rtl/spike_dispatch_pkg.sv
// Shared types and default sizes for the spike dispatcher.
package spike_dispatch_pkg;

  localparam int unsigned DefaultAddressBits   = 12;
  localparam int unsigned DefaultNumberOfUnits = 10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSend  = 2'd1,
    StClear = 2'd2
  } state_e;

endpackage

// File: rtl/lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit and an any-set flag.
module lowest_set_index #(
  parameter int unsigned NUMBER_OF_UNITS = 10,
  localparam int unsigned IdxW = (NUMBER_OF_UNITS > 1) ? $clog2(NUMBER_OF_UNITS) : 1
) (
  input  logic [NUMBER_OF_UNITS-1:0] bitmap_i,
  output logic [IdxW-1:0]            index_o,
  output logic                       any_set_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index_o   = '0;
    any_set_o = 1'b0;
    for (int i = NUMBER_OF_UNITS - 1; i >= 0; i--) begin
      if (bitmap_i[i]) begin
        index_o   = IdxW'(i);
        any_set_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_dispatcher.sv
// Serialises a captured fire bitmap into source addresses on a valid/ready bus, then pulses clear.
// Optional spike counter output enabled by defining SPIKE_DISPATCH_COUNT_EN.
module spike_dispatcher
  import spike_dispatch_pkg::*;
#(
  parameter int unsigned NUMBER_OF_UNITS        = DefaultNumberOfUnits,
  parameter int unsigned NUMBER_OF_ADDRESS_BITS = DefaultAddressBits,
  parameter logic [NUMBER_OF_ADDRESS_BITS-1:0] BASE_ADDRESS = '0,
  localparam int unsigned CountW = $clog2(NUMBER_OF_UNITS + 1)
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              timestep_done,
  input  logic [NUMBER_OF_UNITS-1:0]        spikes,
  output logic [NUMBER_OF_ADDRESS_BITS-1:0] source_address,
  output logic                              address_valid,
  input  logic                              address_ready,
  output logic                              clear,
  output logic                              busy,
`ifdef SPIKE_DISPATCH_COUNT_EN
  output logic [CountW-1:0]                 spike_count,
`endif
  output logic                              overrun
);

  localparam int unsigned IdxW = (NUMBER_OF_UNITS > 1) ? $clog2(NUMBER_OF_UNITS) : 1;

  state_e                            state_q;
  logic [NUMBER_OF_UNITS-1:0]        pending_q;
  logic [NUMBER_OF_ADDRESS_BITS-1:0] addr_q;
  logic                              valid_q;
  logic                              clear_q;
  logic                              overrun_q;

  logic [NUMBER_OF_UNITS-1:0]        enc_in;
  logic [IdxW-1:0]                   enc_idx;
  logic                              enc_any;
  logic [NUMBER_OF_UNITS-1:0]        enc_sel;
  logic [NUMBER_OF_ADDRESS_BITS-1:0] next_addr;
  logic                              transfer;

  // pending_q holds only bits not yet presented; the one on the bus is already removed.
  assign enc_in    = (state_q == StIdle) ? spikes : pending_q;
  assign enc_sel   = NUMBER_OF_UNITS'(1) << enc_idx;
  assign next_addr = BASE_ADDRESS + NUMBER_OF_ADDRESS_BITS'(enc_idx);
  assign transfer  = valid_q && address_ready;

  lowest_set_index #(
    .NUMBER_OF_UNITS(NUMBER_OF_UNITS)
  ) u_lowest_set_index (
    .bitmap_i (enc_in),
    .index_o  (enc_idx),
    .any_set_o(enc_any)
  );

`ifdef SPIKE_DISPATCH_COUNT_EN
  logic [CountW-1:0] count_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
    end else if (state_q == StIdle && timestep_done) begin
      count_q <= '0;
    end else if (state_q == StSend && transfer) begin
      count_q <= count_q + CountW'(1);
    end
  end

  assign spike_count = count_q;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      pending_q <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      clear_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      if (timestep_done && state_q != StIdle) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (timestep_done) begin
            if (enc_any) begin
              pending_q <= spikes & ~enc_sel;
              addr_q    <= next_addr;
              valid_q   <= 1'b1;
              state_q   <= StSend;
            end else begin
              clear_q <= 1'b1;
              state_q <= StClear;
            end
          end
        end
        StSend: begin
          if (transfer) begin
            if (enc_any) begin
              pending_q <= pending_q & ~enc_sel;
              addr_q    <= next_addr;
            end else begin
              valid_q <= 1'b0;
              clear_q <= 1'b1;
              state_q <= StClear;
            end
          end
        end
        StClear: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign source_address = addr_q;
  assign address_valid  = valid_q;
  assign clear          = clear_q;
  assign busy           = (state_q != StIdle);
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_spike_dispatcher.sv
// Directed bench: three dispatchers (bases 0x000, 0x100, 0xFFE) driven by one stimulus stream.
module tb_spike_dispatcher;

  localparam int unsigned N  = 10;
  localparam int unsigned AW = 12;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [AW-1:0] BASES [3] = '{12'h000, 12'h100, 12'hFFE};

  logic          CLK = 1'b0;
  logic          RESET;
  logic          timestep_done;
  logic [N-1:0]  spikes;
  logic          address_ready;
  logic [AW-1:0] src     [3];
  logic          valid   [3];
  logic          clr     [3];
  logic          bsy     [3];
  logic          ovr     [3];
`ifdef SPIKE_DISPATCH_COUNT_EN
  logic [CW-1:0] cnt     [3];
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    spike_dispatcher #(
      .NUMBER_OF_UNITS       (N),
      .NUMBER_OF_ADDRESS_BITS(AW),
      .BASE_ADDRESS          (BASES[g])
    ) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .timestep_done (timestep_done),
      .spikes        (spikes),
      .source_address(src[g]),
      .address_valid (valid[g]),
      .address_ready (address_ready),
      .clear         (clr[g]),
      .busy          (bsy[g]),
`ifdef SPIKE_DISPATCH_COUNT_EN
      .spike_count   (cnt[g]),
`endif
      .overrun       (ovr[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    assert (act === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Compare every instance's outputs; the address is checked only while valid.
  task automatic expect_out(input string tag, input bit v, input int idx, input bit c,
                            input bit b, input bit o);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s/d%0d/valid", tag, k), 32'(valid[k]), 32'(v));
      chk($sformatf("%s/d%0d/clear", tag, k), 32'(clr[k]), 32'(c));
      chk($sformatf("%s/d%0d/busy", tag, k), 32'(bsy[k]), 32'(b));
      chk($sformatf("%s/d%0d/overrun", tag, k), 32'(ovr[k]), 32'(o));
      if (v) begin
        chk($sformatf("%s/d%0d/addr", tag, k), 32'(src[k]), 32'(AW'(BASES[k] + AW'(idx))));
      end
    end
  endtask

  task automatic expect_count(input string tag, input int n);
`ifdef SPIKE_DISPATCH_COUNT_EN
    for (int k = 0; k < 3; k++) chk($sformatf("%s/d%0d/count", tag, k), 32'(cnt[k]), 32'(n));
`else
    if (n < 0) $display("unused %s", tag);
`endif
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // timestep_done held across one edge; returns in cycle t+1.
  task automatic pulse(input logic [N-1:0] bm);
    spikes        = bm;
    timestep_done = 1'b1;
    tick();
    timestep_done = 1'b0;
    spikes        = '0;
  endtask

  initial begin
    RESET         = 1'b1;
    timestep_done = 1'b0;
    spikes        = '0;
    address_ready = 1'b1;
    tick();
    tick();
    expect_out("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) chk($sformatf("reset/d%0d/addr", k), 32'(src[k]), 32'h0);
    expect_count("reset", 0);
    RESET = 1'b0;
    tick();

    // Basic burst: bits 0, 2, 5.
    pulse(10'b0000100101);
    expect_out("burst0", 1'b1, 0, 1'b0, 1'b1, 1'b0);
    tick(); expect_out("burst1", 1'b1, 2, 1'b0, 1'b1, 1'b0);
    tick(); expect_out("burst2", 1'b1, 5, 1'b0, 1'b1, 1'b0);
    tick(); expect_out("burst_clr", 1'b0, 0, 1'b1, 1'b1, 1'b0);
    expect_count("burst_clr", 3);
    tick(); expect_out("burst_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    expect_count("burst_hold", 3);

    // Backpressure while index 2 is on the bus.
    pulse(10'b0000100101);
    expect_out("bp0", 1'b1, 0, 1'b0, 1'b1, 1'b0);
    tick(); expect_out("bp1", 1'b1, 2, 1'b0, 1'b1, 1'b0);
    address_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out($sformatf("bp_hold%0d", i), 1'b1, 2, 1'b0, 1'b1, 1'b0);
    end
    address_ready = 1'b1;
    tick(); expect_out("bp2", 1'b1, 5, 1'b0, 1'b1, 1'b0);
    tick(); expect_out("bp_clr", 1'b0, 0, 1'b1, 1'b1, 1'b0);
    expect_count("bp_clr", 3);
    tick(); expect_out("bp_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Empty timestep.
    pulse('0);
    expect_out("empty_clr", 1'b0, 0, 1'b1, 1'b1, 1'b0);
    expect_count("empty_clr", 0);
    tick(); expect_out("empty_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("empty_quiet", 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Low three bits: the 0xFFE instance wraps to 0x000.
    pulse(10'b0000000111);
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("wrap%0d", i), 1'b1, i, 1'b0, 1'b1, 1'b0);
      tick();
    end
    expect_out("wrap_clr", 1'b0, 0, 1'b1, 1'b1, 1'b0);
    expect_count("wrap_clr", 3);
    tick();

    // All ones: ten transfers in ascending order.
    pulse(10'h3FF);
    for (int i = 0; i < 10; i++) begin
      expect_out($sformatf("ones%0d", i), 1'b1, i, 1'b0, 1'b1, 1'b0);
      tick();
    end
    expect_out("ones_clr", 1'b0, 0, 1'b1, 1'b1, 1'b0);
    expect_count("ones_clr", 10);
    tick();

    // Reset after three transfers of an all-ones burst.
    pulse(10'h3FF);
    tick(); tick(); tick();
    expect_out("rst_mid3", 1'b1, 3, 1'b0, 1'b1, 1'b0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    expect_out("rst_mid_after", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) chk($sformatf("rst_mid/d%0d/addr", k), 32'(src[k]), 32'h0);
    tick(); expect_out("rst_mid_noclr", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    pulse(10'b0000000001);
    expect_out("rst_single", 1'b1, 0, 1'b0, 1'b1, 1'b0);
    tick(); expect_out("rst_single_clr", 1'b0, 0, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("rst_single_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Overrun: second bitmap arrives mid-burst and is dropped.
    pulse(10'b0000100101);
    expect_out("ovr0", 1'b1, 0, 1'b0, 1'b1, 1'b0);
    pulse(10'b1000000000);
    expect_out("ovr1", 1'b1, 2, 1'b0, 1'b1, 1'b1);
    tick(); expect_out("ovr2", 1'b1, 5, 1'b0, 1'b1, 1'b1);
    tick(); expect_out("ovr_clr", 1'b0, 0, 1'b1, 1'b1, 1'b1);
    expect_count("ovr_clr", 3);
    tick(); expect_out("ovr_idle", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    tick(); expect_out("ovr_dropped", 1'b0, 0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
